// File: rtl/controle_telas.sv
// controle_telas: game-phase sequencer for the VGA path; tracks lives and
// switches the active screen renderer only at frame boundaries.
module controle_telas #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int LIVES        = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int BLINK_FRAMES = 8,
  parameter int END_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        start_btn,
  input  logic        player_hit,
  input  logic        enemies_dead,
  input  logic [23:0] title_rgb,
  input  logic [23:0] game_rgb,
  input  logic [23:0] defeat_rgb,
  input  logic [23:0] victory_rgb,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic        game_rst
);
  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    PLAYING   = 3'd1,
    HIT_PAUSE = 3'd2,
    DEFEAT    = 3'd3,
    VICTORY   = 3'd4
  } state_t;
  state_t      state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d, blink_idx;
  logic        start_flag_q, start_flag_d, hit_flag_q, hit_flag_d;
  logic        start_prev_q, hit_prev_q, match_prev_q;
  logic        game_rst_q, game_rst_d;
  logic [23:0] rgb_q, rgb_d;
  logic        match, tick, start_evt, hit_evt, blank;
  always_comb begin
    match        = h_counter == 10'd0 && v_counter == 10'(V_ACTIVE);
    tick         = match && !match_prev_q;
    start_evt    = start_flag_q || (start_btn && !start_prev_q);
    hit_evt      = hit_flag_q || (player_hit && !hit_prev_q);
    start_flag_d = tick ? 1'b0 : start_evt;
    hit_flag_d   = tick ? 1'b0 : hit_evt;
    state_d      = state_q;
    lives_d      = lives_q;
    game_rst_d   = 1'b0;
    case (state_q)
      TITLE: if (tick && start_evt) begin
        state_d    = PLAYING;
        lives_d    = 2'(LIVES);
        game_rst_d = 1'b1;
      end
      PLAYING: if (tick && hit_evt && lives_q == 2'd1) begin
        state_d = DEFEAT;
        lives_d = 2'd0;
      end else if (tick && hit_evt) begin
        lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
        state_d = enemies_dead ? VICTORY : HIT_PAUSE;
      end else if (tick && enemies_dead) begin
        state_d = VICTORY;
      end
      HIT_PAUSE: if (tick && frame_cnt_q == 8'(PAUSE_FRAMES - 1)) state_d = PLAYING;
      DEFEAT, VICTORY: if (tick && start_evt && frame_cnt_q >= 8'(END_FRAMES - 1)) state_d = TITLE;
      default: state_d = TITLE;
    endcase
    frame_cnt_d = !tick ? frame_cnt_q :
                  state_d != state_q ? 8'd0 :
                  frame_cnt_q == 8'hff ? frame_cnt_q : frame_cnt_q + 8'd1;
    // blink: odd multiples of BLINK_FRAMES show black
    blink_idx = frame_cnt_q / 8'(BLINK_FRAMES);
    blank     = h_counter >= 10'(H_ACTIVE) || v_counter >= 10'(V_ACTIVE);
    rgb_d = blank                 ? 24'd0 :
            state_q == TITLE      ? title_rgb :
            state_q == PLAYING    ? game_rgb :
            state_q == HIT_PAUSE  ? (blink_idx[0] ? 24'd0 : game_rgb) :
            state_q == DEFEAT     ? defeat_rgb :
            state_q == VICTORY    ? victory_rgb : 24'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= TITLE;
      lives_q      <= 2'(LIVES);
      frame_cnt_q  <= 8'd0;
      start_flag_q <= 1'b0;
      hit_flag_q   <= 1'b0;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
      match_prev_q <= 1'b0;
      game_rst_q   <= 1'b1;
      rgb_q        <= 24'd0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      frame_cnt_q  <= frame_cnt_d;
      start_flag_q <= start_flag_d;
      hit_flag_q   <= hit_flag_d;
      start_prev_q <= start_btn;
      hit_prev_q   <= player_hit;
      match_prev_q <= match;
      game_rst_q   <= game_rst_d;
      rgb_q        <= rgb_d;
    end
  end
  assign {R, G, B} = rgb_q;
  assign state     = state_q;
  assign lives     = lives_q;
  assign game_rst  = game_rst_q;
endmodule

// File: tb/tb_controle_telas.sv
// tb_controle_telas: frame-level reference model, vector table for the pixel
// mux, directed phase sequences and a long randomized run.
module tb_controle_telas;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_counter, v_counter;
  logic        start_btn, player_hit, enemies_dead;
  logic [23:0] title_rgb, game_rgb, defeat_rgb, victory_rgb;
  logic [7:0]  R, G, B;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic        game_rst;
  int total = 0, bad = 0;
  int m_state, m_lives, m_cnt;
  bit m_sf, m_hf, m_ps, m_ph, m_pm, e_grst;
  logic [23:0] e_rgb;
  typedef struct {
    logic [9:0]  h, v;
    logic [23:0] rgb, exp;
  } vec_t;
  vec_t vecs[8];
  controle_telas dut (
    .clk(clk), .reset_n(reset_n), .h_counter(h_counter), .v_counter(v_counter),
    .start_btn(start_btn), .player_hit(player_hit), .enemies_dead(enemies_dead),
    .title_rgb(title_rgb), .game_rgb(game_rgb), .defeat_rgb(defeat_rgb),
    .victory_rgb(victory_rgb), .R(R), .G(G), .B(B), .state(state), .lives(lives),
    .game_rst(game_rst)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] pixel(int st, int cnt);
    case (st)
      0: return title_rgb;
      1: return game_rgb;
      2: return ((cnt / 8) % 2 == 0) ? game_rgb : 24'd0;
      3: return defeat_rgb;
      4: return victory_rgb;
      default: return 24'd0;
    endcase
  endfunction
  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    bit match, tick, sev, hev;
    int nxt;
    if (!reset_n) begin
      m_state = 0; m_lives = 3; m_cnt = 0;
      m_sf = 0; m_hf = 0; m_ps = 0; m_ph = 0; m_pm = 0;
      e_rgb = 0; e_grst = 1;
    end else begin
      match  = h_counter == 0 && v_counter == 480;
      tick   = match && !m_pm;
      sev    = m_sf || (start_btn && !m_ps);
      hev    = m_hf || (player_hit && !m_ph);
      e_rgb  = (h_counter >= 640 || v_counter >= 480) ? 24'd0 : pixel(m_state, m_cnt);
      e_grst = 0;
      if (tick) begin
        nxt = m_state;
        if (m_state == 0 && sev) begin
          nxt = 1; m_lives = 3; e_grst = 1;
        end else if (m_state == 1 && hev) begin
          if (m_lives == 1) begin
            nxt = 3; m_lives = 0;
          end else begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            nxt = enemies_dead ? 4 : 2;
          end
        end else if (m_state == 1 && enemies_dead) nxt = 4;
        else if (m_state == 2 && m_cnt == 59) nxt = 1;
        else if ((m_state == 3 || m_state == 4) && sev && m_cnt >= 119) nxt = 0;
        m_cnt   = (nxt != m_state) ? 0 : (m_cnt < 255 ? m_cnt + 1 : 255);
        m_state = nxt;
        m_sf = 0; m_hf = 0;
      end else begin
        m_sf = sev; m_hf = hev;
      end
      m_ps = start_btn; m_ph = player_hit; m_pm = match;
    end
  endtask
  task automatic cyc(logic [9:0] h, logic [9:0] v, bit sb, bit ph, bit ed);
    @(negedge clk);
    h_counter = h; v_counter = v;
    start_btn = sb; player_hit = ph; enemies_dead = ed;
    model_step();
    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("lives", 32'(lives), 32'(m_lives));
    check("rgb", 32'({R, G, B}), 32'(e_rgb));
    check("game_rst", 32'(game_rst), 32'(e_grst));
  endtask
  task automatic rnd_rgb();
    title_rgb = 24'($urandom); game_rgb = 24'($urandom);
    defeat_rgb = 24'($urandom); victory_rgb = 24'($urandom);
  endtask
  // Each frame: three off-tick cycles (event pulse on the middle one) then a tick.
  task automatic frames(int n, bit sb, bit ph, bit ed);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        rnd_rgb();
        cyc(10'($urandom_range(1, 799)), 10'($urandom_range(0, 524)), sb && k == 1, ph && k == 1, ed);
      end
      rnd_rgb();
      cyc(10'd0, 10'd480, 1'b0, 1'b0, ed);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    rnd_rgb();
    cyc(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    cyc(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask
  initial begin
    bit ed_r;
    int r;
    vecs[0] = '{h: 10'd0,    v: 10'd0,    rgb: 24'h112233, exp: 24'h112233};
    vecs[1] = '{h: 10'd639,  v: 10'd479,  rgb: 24'h445566, exp: 24'h445566};
    vecs[2] = '{h: 10'd640,  v: 10'd0,    rgb: 24'h778899, exp: 24'h000000};
    vecs[3] = '{h: 10'd0,    v: 10'd479,  rgb: 24'hAABBCC, exp: 24'hAABBCC};
    vecs[4] = '{h: 10'd639,  v: 10'd480,  rgb: 24'hDDEEFF, exp: 24'h000000};
    vecs[5] = '{h: 10'd1023, v: 10'd100,  rgb: 24'h123456, exp: 24'h000000};
    vecs[6] = '{h: 10'd100,  v: 10'd1023, rgb: 24'h654321, exp: 24'h000000};
    vecs[7] = '{h: 10'd320,  v: 10'd240,  rgb: 24'hFFFFFF, exp: 24'hFFFFFF};
    h_counter = 0; v_counter = 0; start_btn = 0; player_hit = 0; enemies_dead = 0;
    rnd_rgb();
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_lives", 32'(lives), 32'd3);
    check("reset_rgb", 32'({R, G, B}), 32'd0);
    check("reset_game_rst", 32'(game_rst), 32'd1);
    foreach (vecs[i]) begin
      title_rgb = vecs[i].rgb;
      cyc(vecs[i].h, vecs[i].v, 1'b0, 1'b0, 1'b0);
      check("vec_rgb", 32'({R, G, B}), 32'(vecs[i].exp));
    end
    // start -> PLAYING with a one-cycle game_rst
    frames(1, 1, 0, 0);
    check("t1_state", 32'(state), 32'd1);
    check("t1_lives", 32'(lives), 32'd3);
    check("t1_rst_on", 32'(game_rst), 32'd1);
    cyc(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    check("t1_rst_off", 32'(game_rst), 32'd0);
    // hit -> HIT_PAUSE, blink window, return after 60 frames
    frames(1, 0, 1, 0);
    check("t2_state", 32'(state), 32'd2);
    check("t2_lives", 32'(lives), 32'd2);
    frames(7, 0, 0, 0);
    game_rgb = 24'h123456;
    cyc(10'd100, 10'd100, 1'b0, 1'b0, 1'b0);
    check("t2_blink_on", 32'({R, G, B}), 32'h123456);
    frames(1, 0, 0, 0);
    game_rgb = 24'h123456;
    cyc(10'd100, 10'd100, 1'b0, 1'b0, 1'b0);
    check("t2_blink_off", 32'({R, G, B}), 32'd0);
    frames(51, 0, 0, 0);
    check("t2_still_pause", 32'(state), 32'd2);
    frames(1, 0, 0, 0);
    check("t2_back", 32'(state), 32'd1);
    // two more hits -> DEFEAT
    frames(1, 0, 1, 0);
    frames(60, 0, 0, 0);
    check("t3_lives1", 32'(lives), 32'd1);
    frames(1, 0, 1, 0);
    check("t3_state", 32'(state), 32'd3);
    check("t3_lives", 32'(lives), 32'd0);
    defeat_rgb = 24'hABCDEF;
    cyc(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    check("t3_rgb", 32'({R, G, B}), 32'hABCDEF);
    // early start is dropped; start after END_FRAMES returns to TITLE
    frames(9, 0, 0, 0);
    frames(1, 1, 0, 0);
    check("t5_early", 32'(state), 32'd3);
    frames(110, 0, 0, 0);
    check("t5_no_start", 32'(state), 32'd3);
    frames(1, 1, 0, 0);
    check("t5_title", 32'(state), 32'd0);
    // hit with enemies_dead: lives=2 -> VICTORY, lives=1 -> DEFEAT
    frames(1, 1, 0, 0);
    frames(1, 0, 1, 0);
    frames(60, 0, 0, 0);
    frames(1, 0, 1, 1);
    check("t4_victory", 32'(state), 32'd4);
    check("t4_victory_lives", 32'(lives), 32'd1);
    frames(120, 0, 0, 0);
    frames(1, 1, 0, 0);
    frames(1, 1, 0, 0);
    check("t4_restart", 32'(lives), 32'd3);
    frames(1, 0, 1, 0);
    frames(60, 0, 0, 0);
    frames(1, 0, 1, 0);
    frames(60, 0, 0, 0);
    frames(1, 0, 1, 1);
    check("t4_defeat", 32'(state), 32'd3);
    check("t4_defeat_lives", 32'(lives), 32'd0);
    // reset mid-game and held frame-tick coordinates
    do_reset();
    frames(1, 1, 0, 0);
    reset_n = 1'b0;
    cyc(10'd700, 10'd100, 1'b0, 1'b0, 1'b0);
    check("t6_state", 32'(state), 32'd0);
    check("t6_rgb", 32'({R, G, B}), 32'd0);
    check("t6_game_rst", 32'(game_rst), 32'd1);
    for (int i = 0; i < 3; i++) cyc(10'd0, 10'd480, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 10'd480, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
    check("t6_held_match", 32'(state), 32'd0);
    cyc(10'd3, 10'd3, 1'b0, 1'b0, 1'b0);
    cyc(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
    check("t6_next_tick", 32'(state), 32'd1);
    // randomized run against the model
    ed_r = 0;
    for (int i = 0; i < 20000; i++) begin
      reset_n = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 99) == 0) ed_r = !ed_r;
      rnd_rgb();
      r = $urandom_range(0, 5);
      cyc(r == 0 ? 10'd0 : r == 1 ? 10'd0 : 10'($urandom_range(0, 1023)),
          r == 0 ? 10'd480 : 10'($urandom_range(0, 1023)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, ed_r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
